// File: rtl/mem_handshake_unit.sv
// Word-addressed memory answering a CPU bus with 4-phase read/write handshakes
// of programmable latency, plus a side-band preload port.
module mem_handshake_unit #(
  parameter int WORD_SIZE  = 16,
  parameter int DEPTH_LOG2 = 8,
  parameter int LATENCY    = 2
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  readM,
  input  logic                  writeM,
  input  logic [WORD_SIZE-1:0]  address,
  inout  wire  [WORD_SIZE-1:0]  data,
  output logic                  inputReady,
  output logic                  ackOutput,
  input  logic                  load_en,
  input  logic [DEPTH_LOG2-1:0] load_addr,
  input  logic [WORD_SIZE-1:0]  load_data
);

  localparam logic [2:0] IDLE    = 3'd0;
  localparam logic [2:0] RD_WAIT = 3'd1;
  localparam logic [2:0] RD_DONE = 3'd2;
  localparam logic [2:0] WR_WAIT = 3'd3;
  localparam logic [2:0] WR_DONE = 3'd4;
  localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

  logic [WORD_SIZE-1:0]  mem [0:(2**DEPTH_LOG2)-1];

  logic [2:0]            state_q, state_d;
  logic [3:0]            cnt_q, cnt_d;
  logic [DEPTH_LOG2-1:0] idx_q, idx_d;
  logic [WORD_SIZE-1:0]  wdata_q, wdata_d;
  logic [WORD_SIZE-1:0]  rdata_q, rdata_d;
  logic                  rdy_q, rdy_d;
  logic                  ack_q, ack_d;
  logic                  commit_s;
  logic                  addr_unused_s;

  // Upper address bits are deliberately dropped so addresses wrap.
  assign addr_unused_s = ^address[WORD_SIZE-1:DEPTH_LOG2];

  // Handshake FSM next-state, response flags and read-capture path.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    idx_d    = idx_q;
    wdata_d  = wdata_q;
    rdata_d  = rdata_q;
    rdy_d    = rdy_q;
    ack_d    = ack_q;
    commit_s = 1'b0;
    case (state_q)
      IDLE: begin
        if (readM) begin
          idx_d   = address[DEPTH_LOG2-1:0];
          cnt_d   = CNT_INIT;
          state_d = RD_WAIT;
        end else if (writeM) begin
          idx_d   = address[DEPTH_LOG2-1:0];
          wdata_d = data;
          cnt_d   = CNT_INIT;
          state_d = WR_WAIT;
        end else begin
          state_d = IDLE;
        end
      end
      RD_WAIT: begin
        if (!readM) begin
          cnt_d   = 4'd0;
          state_d = IDLE;
        end else if (cnt_q == 4'd0) begin
          rdata_d = mem[idx_q];
          rdy_d   = 1'b1;
          state_d = RD_DONE;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      RD_DONE: begin
        if (!readM) begin
          rdy_d   = 1'b0;
          state_d = IDLE;
        end else begin
          rdy_d = 1'b1;
        end
      end
      WR_WAIT: begin
        if (!writeM) begin
          cnt_d   = 4'd0;
          state_d = IDLE;
        end else if (cnt_q == 4'd0) begin
          commit_s = 1'b1;
          ack_d    = 1'b1;
          state_d  = WR_DONE;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      WR_DONE: begin
        if (!writeM) begin
          ack_d   = 1'b0;
          state_d = IDLE;
        end else begin
          ack_d = 1'b1;
        end
      end
      default: begin
        rdy_d   = 1'b0;
        ack_d   = 1'b0;
        cnt_d   = 4'd0;
        state_d = IDLE;
      end
    endcase
  end

  // Control state and response registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      idx_q   <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      rdy_q   <= 1'b0;
      ack_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      rdy_q   <= rdy_d;
      ack_q   <= ack_d;
    end
  end

  // Storage is not reset; a CPU commit overrides a same-index preload.
  always_ff @(posedge clk) begin
    if (load_en) begin
      mem[load_addr] <= load_data;
    end
    if (commit_s) begin
      mem[idx_q] <= wdata_q;
    end
  end

  assign inputReady = rdy_q;
  assign ackOutput  = ack_q;
  assign data       = rdy_q ? rdata_q : {WORD_SIZE{1'bz}};

endmodule

// File: tb/tb_mem_handshake_unit.sv
// Directed self-checking bench for mem_handshake_unit (LATENCY=2 main instance,
// LATENCY=3 second instance for the abort and longer-latency cases).
module tb_mem_handshake_unit;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        readM = 1'b0, writeM = 1'b0;
  logic [15:0] address = 16'h0000;
  logic [15:0] cpu_drv = 16'h0000;
  logic        cpu_oe = 1'b0;
  wire  [15:0] bus;
  logic        inputReady, ackOutput;
  logic        load_en = 1'b0;
  logic [7:0]  load_addr = 8'h00;
  logic [15:0] load_data = 16'h0000;

  logic        rd3 = 1'b0, wr3 = 1'b0;
  logic [15:0] addr3 = 16'h0000;
  logic [15:0] drv3 = 16'h0000;
  logic        oe3 = 1'b0;
  wire  [15:0] bus3;
  logic        ir3, ack3;

  int total = 0;
  int bad = 0;

  assign bus  = cpu_oe ? cpu_drv : 16'hzzzz;
  assign bus3 = oe3 ? drv3 : 16'hzzzz;

  always #5 clk = ~clk;

  mem_handshake_unit #(.WORD_SIZE(16), .DEPTH_LOG2(8), .LATENCY(2)) u_dut (
    .clk(clk), .reset_n(reset_n), .readM(readM), .writeM(writeM),
    .address(address), .data(bus), .inputReady(inputReady), .ackOutput(ackOutput),
    .load_en(load_en), .load_addr(load_addr), .load_data(load_data)
  );

  mem_handshake_unit #(.WORD_SIZE(16), .DEPTH_LOG2(8), .LATENCY(3)) u_dut3 (
    .clk(clk), .reset_n(reset_n), .readM(rd3), .writeM(wr3),
    .address(addr3), .data(bus3), .inputReady(ir3), .ackOutput(ack3),
    .load_en(load_en), .load_addr(load_addr), .load_data(load_data)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic preload(input logic [7:0] a, input logic [15:0] d);
    load_en = 1'b1; load_addr = a; load_data = d;
    tick();
    load_en = 1'b0;
  endtask

  // Full read handshake on the LATENCY=2 instance, holding the request extra cycles.
  task automatic do_read(input logic [15:0] a, input logic [15:0] exp, input string nm, input int hold);
    address = a; readM = 1'b1;
    tick();
    total++; if (inputReady !== 1'b0) begin bad++; $display("FAIL %s_e0 got=%b want=0", nm, inputReady); end
    tick();
    total++; if (inputReady !== 1'b0) begin bad++; $display("FAIL %s_e1 got=%b want=0", nm, inputReady); end
    tick();
    total++; if (inputReady !== 1'b1) begin bad++; $display("FAIL %s_rdy got=%b want=1", nm, inputReady); end
    total++; if (bus !== exp) begin bad++; $display("FAIL %s_data got=%h want=%h", nm, bus, exp); end
    for (int i = 0; i < hold; i++) begin
      tick();
      total++; if (inputReady !== 1'b1 || bus !== exp) begin bad++; $display("FAIL %s_hold rdy=%b data=%h want 1/%h", nm, inputReady, bus, exp); end
    end
    readM = 1'b0;
    tick();
    total++; if (inputReady !== 1'b0) begin bad++; $display("FAIL %s_drop got=%b want=0", nm, inputReady); end
    cpu_drv = ~exp; cpu_oe = 1'b1;
    #1;
    total++; if (bus !== ~exp) begin bad++; $display("FAIL %s_release bus=%h want=%h", nm, bus, ~exp); end
    cpu_oe = 1'b0;
  endtask

  // Full write handshake; the bus changes after acceptance and must be ignored.
  task automatic do_write(input logic [15:0] a, input logic [15:0] d, input string nm);
    address = a; writeM = 1'b1; cpu_drv = d; cpu_oe = 1'b1;
    tick();
    cpu_drv = ~d;
    total++; if (ackOutput !== 1'b0) begin bad++; $display("FAIL %s_e0 got=%b want=0", nm, ackOutput); end
    tick();
    total++; if (ackOutput !== 1'b0) begin bad++; $display("FAIL %s_e1 got=%b want=0", nm, ackOutput); end
    tick();
    total++; if (ackOutput !== 1'b1) begin bad++; $display("FAIL %s_ack got=%b want=1", nm, ackOutput); end
    writeM = 1'b0; cpu_oe = 1'b0;
    tick();
    total++; if (ackOutput !== 1'b0) begin bad++; $display("FAIL %s_drop got=%b want=0", nm, ackOutput); end
  endtask

  task automatic test_reset();
    #2;
    total++; if (inputReady !== 1'b0 || ackOutput !== 1'b0) begin bad++; $display("FAIL reset_out rdy=%b ack=%b want 0/0", inputReady, ackOutput); end
    cpu_drv = 16'h5A5A; cpu_oe = 1'b1;
    #1;
    total++; if (bus !== 16'h5A5A) begin bad++; $display("FAIL reset_bus got=%h want=5a5a", bus); end
    cpu_oe = 1'b0;
    @(negedge clk); reset_n = 1'b1;
    tick();
  endtask

  task automatic test_read_handshake();
    preload(8'h05, 16'h1234);
    do_read(16'h0005, 16'h1234, "read", 1);
  endtask

  task automatic test_write_readback();
    do_write(16'h0010, 16'hBEEF, "wr10");
    do_read(16'h0010, 16'hBEEF, "rb10", 0);
  endtask

  task automatic test_wrap();
    do_write(16'h0103, 16'h00A5, "wrwrap");
    do_read(16'h0003, 16'h00A5, "rdwrap", 0);
  endtask

  task automatic test_abort_lat3();
    preload(8'h20, 16'h1111);
    addr3 = 16'h0020; wr3 = 1'b1; drv3 = 16'h5555; oe3 = 1'b1;
    tick();
    wr3 = 1'b0; oe3 = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      total++; if (ack3 !== 1'b0) begin bad++; $display("FAIL abort_ack cyc=%0d got=%b want=0", i, ack3); end
    end
    rd3 = 1'b1;
    tick();
    tick();
    tick();
    total++; if (ir3 !== 1'b0) begin bad++; $display("FAIL lat3_early got=%b want=0", ir3); end
    tick();
    total++; if (ir3 !== 1'b1) begin bad++; $display("FAIL lat3_rdy got=%b want=1", ir3); end
    total++; if (bus3 !== 16'h1111) begin bad++; $display("FAIL abort_mem got=%h want=1111", bus3); end
    rd3 = 1'b0;
    tick();
    total++; if (ir3 !== 1'b0) begin bad++; $display("FAIL lat3_drop got=%b want=0", ir3); end
  endtask

  task automatic test_simultaneous();
    address = 16'h0005; readM = 1'b1; writeM = 1'b1; cpu_drv = 16'hFFFF; cpu_oe = 1'b1;
    tick();
    cpu_oe = 1'b0;
    tick();
    tick();
    total++; if (inputReady !== 1'b1 || ackOutput !== 1'b0) begin bad++; $display("FAIL both_resp rdy=%b ack=%b want 1/0", inputReady, ackOutput); end
    total++; if (bus !== 16'h1234) begin bad++; $display("FAIL both_data got=%h want=1234", bus); end
    readM = 1'b0; writeM = 1'b0;
    tick();
    do_read(16'h0005, 16'h1234, "both_mem", 0);
  endtask

  task automatic test_load_collision();
    address = 16'h0010; writeM = 1'b1; cpu_drv = 16'h2222; cpu_oe = 1'b1;
    tick();
    tick();
    load_en = 1'b1; load_addr = 8'h10; load_data = 16'h0001;
    tick();
    load_en = 1'b0;
    total++; if (ackOutput !== 1'b1) begin bad++; $display("FAIL coll_ack got=%b want=1", ackOutput); end
    writeM = 1'b0; cpu_oe = 1'b0;
    tick();
    do_read(16'h0010, 16'h2222, "coll_mem", 0);
  endtask

  task automatic test_reset_mid();
    address = 16'h0005; readM = 1'b1;
    tick();
    #2; reset_n = 1'b0; #1;
    total++; if (inputReady !== 1'b0 || ackOutput !== 1'b0) begin bad++; $display("FAIL rstwait_out rdy=%b ack=%b want 0/0", inputReady, ackOutput); end
    readM = 1'b0;
    @(negedge clk); reset_n = 1'b1;
    tick();
    do_read(16'h0005, 16'h1234, "rstwait_rd", 0);
    readM = 1'b1;
    tick(); tick(); tick();
    #2; reset_n = 1'b0; #1;
    total++; if (inputReady !== 1'b0) begin bad++; $display("FAIL rstdone_rdy got=%b want=0", inputReady); end
    cpu_drv = 16'hEDCB; cpu_oe = 1'b1;
    #1;
    total++; if (bus !== 16'hEDCB) begin bad++; $display("FAIL rstdone_bus got=%h want=edcb", bus); end
    cpu_oe = 1'b0; readM = 1'b0;
    @(negedge clk); reset_n = 1'b1;
    tick();
    preload(8'h30, 16'h0BAD);
    address = 16'h0030; writeM = 1'b1; cpu_drv = 16'hAAAA; cpu_oe = 1'b1;
    tick();
    tick();
    #2; reset_n = 1'b0; #1;
    writeM = 1'b0; cpu_oe = 1'b0;
    @(negedge clk); reset_n = 1'b1;
    tick();
    total++; if (ackOutput !== 1'b0) begin bad++; $display("FAIL rstwr_ack got=%b want=0", ackOutput); end
    do_read(16'h0030, 16'h0BAD, "rstwr_mem", 0);
  endtask

  task automatic test_load_during_read();
    address = 16'h0005; readM = 1'b1;
    tick();
    tick();
    load_en = 1'b1; load_addr = 8'h05; load_data = 16'h7777;
    tick();
    total++; if (inputReady !== 1'b1 || bus !== 16'h1234) begin bad++; $display("FAIL ldrd_cap rdy=%b data=%h want 1/1234", inputReady, bus); end
    load_data = 16'h6666;
    tick();
    load_en = 1'b0;
    total++; if (bus !== 16'h1234) begin bad++; $display("FAIL ldrd_hold got=%h want=1234", bus); end
    readM = 1'b0;
    tick();
    do_read(16'h0005, 16'h6666, "ldrd_new", 0);
  endtask

  initial begin
    test_reset();
    test_read_handshake();
    test_write_readback();
    test_wrap();
    test_abort_lat3();
    test_simultaneous();
    test_load_collision();
    test_reset_mid();
    test_load_during_read();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mem_handshake_unit.md
# mem_handshake_unit

Word-addressed memory that sits directly downstream of the single-cycle CPU and answers its memory bus. It services `readM` requests by driving the shared `data` bus and raising `inputReady`, and it services `writeM` requests by committing the bus word and raising `ackOutput`. Both transactions use a 4-phase handshake with programmable latency. A side-band load port lets the bench or boot logic preload program and data words.

## Interface

Parameters:
- `WORD_SIZE`, 16: data and address width.
- `DEPTH_LOG2`, 8: memory holds 2^DEPTH_LOG2 words.
- `LATENCY`, 2: cycles from request acceptance to response. Legal range 1..15.

Ports:
- `clk`  in  1  rising-edge clock.
- `reset_n`  in  1  asynchronous, active-low reset.
- `readM`  in  1  CPU read request (level).
- `writeM`  in  1  CPU write request (level).
- `address`  in  WORD_SIZE  CPU word address.
- `data`  inout  WORD_SIZE  shared bus. CPU drives it during writes; this block drives it only during read response.
- `inputReady`  out  1  read data valid on `data`.
- `ackOutput`  out  1  write committed.
- `load_en`  in  1  preload strobe.
- `load_addr`  in  DEPTH_LOG2  preload address.
- `load_data`  in  WORD_SIZE  preload word.

## Operation

- Memory index is `address[DEPTH_LOG2-1:0]`. Upper address bits are ignored, so addresses wrap modulo 2^DEPTH_LOG2.
- Memory contents are not affected by reset. At power-up they are X until loaded or written.
- FSM states: IDLE, RD_WAIT, RD_DONE, WR_WAIT, WR_DONE. State, counter, latched address and latched data are the only control state.

**IDLE**
- `readM`=1 at an edge: latch the index, load `cnt`=LATENCY-1, go to RD_WAIT.
- Otherwise, `writeM`=1 at an edge: latch the index and the `data` bus word, load `cnt`=LATENCY-1, go to WR_WAIT.
- Both `readM` and `writeM` asserted: the read wins and the write is ignored.

**RD_WAIT / WR_WAIT**
- If the request line is still 1 and `cnt`==0, advance to RD_DONE / WR_DONE; otherwise decrement `cnt`.
- If the request line drops, abort to IDLE. No response is given and no memory write occurs.

**Entry to RD_DONE**
- Capture `mem[index]` into the output register.
- Set `inputReady`=1 and drive `data` from the output register.

**Entry to WR_DONE**
- Write the latched word into `mem[index]`.
- Set `ackOutput`=1.

**RD_DONE / WR_DONE**
- Hold the response while the matching request stays 1.
- At the first edge where it is sampled 0, clear the response, release `data` to Z, and go to IDLE.
- A new request is accepted no earlier than the following edge.

**Load port**
- `load_en`=1 at an edge writes `load_data` to `mem[load_addr]` in any state.
- If it hits the same index as a WR_DONE commit in the same edge, the CPU write wins.
- A load never changes a word already captured for an in-flight read response.

## Timing

- Reset asserted: state=IDLE, `cnt`=0, `inputReady`=0, `ackOutput`=0, `data` released to Z, all taking effect immediately.
- Reset mid-transaction discards the pending read or write; no memory write occurs.
- Request sampled at edge k:
  - With no abort, `inputReady` or `ackOutput` rises after edge k+LATENCY.
  - Each response is high for at least 1 cycle.
  - The response falls after the first edge at which the request is sampled 0.
- `data` is driven exactly while `inputReady`=1. No other cycle drives it, so there is no bus contention with CPU writes.
- Memory read is synchronous (captured at the edge), not combinational from `address`.
- Bus `data` during writes is sampled only at the accepting edge; later bus changes are ignored.

## Test plan

- Read handshake:
  - Stimulus: preload mem[0x05]=0x1234, LATENCY=2, `address`=0x0005, `readM` high at edge 0.
  - Required: `inputReady` high after edge 2 with `data`=0x1234; drop `readM` at edge 3 → `inputReady`=0 and `data`=Z after edge 3.
- Write then read back:
  - Stimulus: `writeM` with `address`=0x0010, `data`=0xBEEF.
  - Required: `ackOutput` high after 2 edges; after handshake completes, a read of 0x0010 returns 0xBEEF.
- Address wrap:
  - Stimulus: write 0x00A5 to `address`=0x0103 (DEPTH_LOG2=8).
  - Required: a read of 0x0003 returns 0x00A5.
- Abort:
  - Stimulus: `writeM` to 0x0020 (prior content 0x1111) deasserted after 1 cycle with LATENCY=3.
  - Required: no `ackOutput`; mem[0x20] still reads 0x1111.
- Simultaneous requests and load collision:
  - Stimulus 1: `readM`=`writeM`=1 at 0x0005 with `data`=0xFFFF.
  - Required: read returns 0x1234 and memory is unchanged.
  - Stimulus 2: `load_en` to 0x10 with 0x0001 on the same edge as a WR_DONE commit of 0x2222.
  - Required: mem[0x10]=0x2222.
- Reset mid-read:
  - Stimulus: assert `reset_n`=0 between clock edges during RD_WAIT.
  - Required: outputs 0 and `data`=Z immediately; after release, a new read completes normally with contents intact.
